// File: rtl/wfifo_wr_arb.sv
// wfifo_wr_arb: two-requester round-robin write arbiter and write-side pointer/flag logic
// for an asynchronous FIFO (Gray write pointer, full / almost-full / occupancy). Rev 1.0
`default_nettype none

module wfifo_wr_arb #(
    parameter int ADDRSIZE  = 4,
    parameter int DSIZE     = 8,
    parameter int AFULL_LVL = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                req0_valid,
    input  logic [DSIZE-1:0]    req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [DSIZE-1:0]    req1_data,
    output logic                req1_ready,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [DSIZE-1:0]    wdata,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel
);

    localparam logic [ADDRSIZE:0] AFULL_THR = (ADDRSIZE+1)'(AFULL_LVL);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbin_next;
    logic [ADDRSIZE:0] wptr_next;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] level_next;
    logic              full_next;
    logic              afull_next;
    logic              last_grant;
    logic              gnt0;
    logic              gnt1;

    // Grants are suppressed while in reset so no handshake can land during it.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (wrst_n && !wfull) begin
            if (req0_valid && req1_valid) begin
                if (last_grant) gnt0 = 1'b1;
                else            gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign wclken     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign waddr      = wbin[ADDRSIZE-1:0];
    assign wdata      = gnt0 ? req0_data : (gnt1 ? req1_data : '0);

    assign wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wclken};
    assign wptr_next  = (wbin_next >> 1) ^ wbin_next;

    always_comb begin
        rbin[ADDRSIZE] = wq2_rptr[ADDRSIZE];
        for (int i = ADDRSIZE-1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    // Full when the next write pointer is one lap ahead of the synchronized read pointer.
    assign full_next  = (wptr_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    assign level_next = wbin_next - rbin;
    assign afull_next = (level_next >= AFULL_THR);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin       <= '0;
            wptr       <= '0;
            wfull      <= 1'b0;
            wafull     <= 1'b0;
            wlevel     <= '0;
            last_grant <= 1'b1;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wptr_next;
            wfull  <= full_next;
            wafull <= afull_next;
            wlevel <= level_next;
            if (gnt0 || gnt1) begin
                last_grant <= gnt1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wfifo_wr_arb.sv
// tb_wfifo_wr_arb: randomized self-checking bench; a word-count model predicts grants and flags.
`default_nettype none

module tb_wfifo_wr_arb;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic [4:0] wq2_rptr;
    logic       wclken;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [4:0] wptr;
    logic       wfull, wafull;
    logic [4:0] wlevel;

    wfifo_wr_arb #(.ADDRSIZE(4), .DSIZE(8), .AFULL_LVL(12)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .wq2_rptr(wq2_rptr), .wclken(wclken), .waddr(waddr), .wdata(wdata),
        .wptr(wptr), .wfull(wfull), .wafull(wafull), .wlevel(wlevel)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    // Model: words written and words read as plain counts, plus last winner.
    int   wcount, rcount, mlast, mlevel;
    bit   mfull, mafull;
    logic [4:0] prev_wptr;

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wcount = 0; rcount = 0; mlast = 1; mlevel = 0;
        mfull = 0; mafull = 0; prev_wptr = '0;
        wq2_rptr = '0;
    endtask

    // Entered #1 after a rising edge with inputs driven; exits #1 after the next one.
    task automatic cycle();
        int eg;
        #4;
        if (!wrst_n || mfull)          eg = -1;
        else if (req0_valid && req1_valid) eg = (mlast == 1) ? 0 : 1;
        else if (req0_valid)           eg = 0;
        else if (req1_valid)           eg = 1;
        else                           eg = -1;
        chk("req0_ready", req0_ready, eg == 0);
        chk("req1_ready", req1_ready, eg == 1);
        chk("wclken", wclken, eg >= 0);
        chk("waddr", waddr, wcount % 16);
        chk("wdata", wdata, eg == 0 ? req0_data : (eg == 1 ? req1_data : 0));
        chk("wptr", wptr, gray(wcount));
        chk("wfull", wfull, mfull);
        chk("wafull", wafull, mafull);
        chk("wlevel", wlevel, mlevel);
        if (wptr != prev_wptr) chk("wptr_onebit", $countones(wptr ^ prev_wptr), 1);
        prev_wptr = wptr;
        @(posedge wclk);
        if (wrst_n) begin
            if (eg >= 0) begin
                wcount++;
                mlast = eg;
            end
            mlevel = wcount - rcount;
            mfull  = (mlevel == 16);
            mafull = (mlevel >= 12);
        end
        #1;
    endtask

    task automatic set_reader(input int n);
        rcount   = n;
        wq2_rptr = gray(n);
    endtask

    initial begin
        wrst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
        model_reset();
        @(posedge wclk); #1;
        cycle();
        chk("lit_rst_wfull", wfull, 0);
        chk("lit_rst_wlevel", wlevel, 0);
        wrst_n = 1'b1;

        // Single requester fills the FIFO with the reader parked at 0.
        req0_valid = 1;
        for (int i = 0; i < 18; i++) begin
            if (i == 2) chk("lit_wptr2", wptr, 3);
            req0_data = 8'($urandom);
            cycle();
        end
        chk("lit_full", wfull, 1);
        chk("lit_level16", wlevel, 16);
        chk("lit_afull", wafull, 1);

        // Reader frees one slot: one more write, then full again.
        set_reader(1);
        for (int i = 0; i < 3; i++) begin
            req0_data = 8'($urandom);
            cycle();
        end
        chk("lit_refull", wfull, 1);

        // Reader keeps pace, both requesters contend.
        req1_valid = 1;
        for (int i = 0; i < 14; i++) begin
            set_reader(wcount);
            req0_data = 8'($urandom);
            req1_data = 8'($urandom);
            cycle();
        end

        // Random traffic with a bursty reader; wraps the pointer many times.
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_data  = 8'($urandom);
            req1_data  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) set_reader(rcount + $urandom_range(0, wcount - rcount));
            cycle();
        end

        // Reset in the middle of operation with seven words outstanding.
        wrst_n = 1'b0;
        model_reset();
        req0_valid = 0; req1_valid = 0;
        cycle();
        wrst_n = 1'b1;
        req0_valid = 1;
        for (int i = 0; i < 7; i++) begin
            req0_data = 8'($urandom);
            cycle();
        end
        req0_valid = 0;
        cycle();
        chk("lit_level7", wlevel, 7);
        req0_valid = 1; req1_valid = 1;
        req0_data = 8'hA5; req1_data = 8'h5A;
        wrst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        wrst_n = 1'b1;
        cycle();
        chk("lit_second_grant1", req1_ready, 1);
        chk("lit_level1", wlevel, 1);
        cycle();
        chk("lit_level2", wlevel, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wfifo_wr_arb.md
WFIFO_WR_ARB -- requirements
Module: wfifo_wr_arb

Interface
- REQ-001: Parameter ADDRSIZE, default 4: FIFO address width; depth = 2^ADDRSIZE entries.
- REQ-002: Parameter DSIZE, default 8: data word width.
- REQ-003: Parameter AFULL_LVL, default 12: occupancy at or above which wafull asserts; legal range 1..2^ADDRSIZE.
- REQ-004: wclk  input  1  write-domain clock; all state changes on its rising edge.
- REQ-005: wrst_n  input  1  reset, asynchronous, active-low.
- REQ-006: req0_valid  input  1  requester 0 has a word to write.
- REQ-007: req0_data  input  DSIZE  requester 0 write data.
- REQ-008: req0_ready  output  1  requester 0 word accepted this cycle.
- REQ-009: req1_valid  input  1  requester 1 has a word to write.
- REQ-010: req1_data  input  DSIZE  requester 1 write data.
- REQ-011: req1_ready  output  1  requester 1 word accepted this cycle.
- REQ-012: wq2_rptr  input  ADDRSIZE+1  Gray-coded read pointer, already two-flop synchronized into wclk.
- REQ-013: wclken  output  1  FIFO memory write enable.
- REQ-014: waddr  output  ADDRSIZE  FIFO memory write address.
- REQ-015: wdata  output  DSIZE  FIFO memory write data.
- REQ-016: wptr  output  ADDRSIZE+1  registered Gray-coded write pointer, sent to the read domain.
- REQ-017: wfull  output  1  registered full flag.
- REQ-018: wafull  output  1  registered almost-full flag.
- REQ-019: wlevel  output  ADDRSIZE+1  registered occupancy, as seen from the write side.

Function
- REQ-020: The block SHALL hold the binary write pointer wbin (ADDRSIZE+1 bits) and keep wptr = (wbin>>1)^wbin.
- REQ-021: Grant SHALL be computed combinationally and SHALL be issued only when wfull=0.
- REQ-022: Only one requester valid: that requester SHALL receive the grant.
- REQ-023: Both requesters valid: the requester not granted most recently SHALL receive the grant (round-robin); the last_grant register SHALL update only on a grant.
- REQ-024: req0_ready and req1_ready SHALL be one-hot or zero, and the granted ready SHALL equal the grant; a handshake is valid&ready in the same cycle.
- REQ-025: wclken SHALL be the OR of the two handshakes; waddr SHALL be wbin[ADDRSIZE-1:0]; wdata SHALL be the granted requester's data, or 0 when no grant.
- REQ-026: On wclken, wbin SHALL increment by 1 modulo 2^(ADDRSIZE+1); otherwise wbin SHALL hold.
- REQ-027: wfull SHALL register (gray(wbin_next) == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- REQ-028: wlevel SHALL register (wbin_next - gray2bin(wq2_rptr)) modulo 2^(ADDRSIZE+1); its range is 0..2^ADDRSIZE.
- REQ-029: wafull SHALL register (level_next >= AFULL_LVL).
- REQ-030: While wfull=1, both readies SHALL be 0, wbin SHALL hold, and valid inputs SHALL be backpressured, not dropped.
- REQ-031: Flags SHALL be pessimistic: they deassert at least 2 wclk cycles after the read side frees space; wfull SHALL never be 0 while 2^ADDRSIZE words are unread.
- REQ-032: Pointer wrap from 2^(ADDRSIZE+1)-1 to 0 SHALL be seamless, with no flag glitch.
- REQ-033: A requester SHALL keep valid and data stable until ready; the block SHALL not require this for correctness of its own state.

Reset
- REQ-034: While wrst_n=0, the block SHALL force wbin=0, wptr=0, wfull=0, wafull=0, wlevel=0, and last_grant=1, so that requester 0 wins the first contention.
- REQ-035: With no valid requests, wclken, req0_ready and req1_ready SHALL be 0 from reset.
- REQ-036: Reset asserted mid-operation SHALL return all state to reset values immediately; any in-flight handshake is discarded.

Verification
- REQ-037: Reset, then req0_valid=1 only, wq2_rptr=0 for 16 cycles -> 16 writes to waddr 0..15; wfull=1 after the 16th edge; wlevel=16; wafull set once wlevel reaches 12.
- REQ-038: Both valid continuously, FIFO empty -> grants alternate 0,1,0,1...; wdata alternates accordingly; no grant is issued twice in a row while both remain valid.
- REQ-039: FIFO full, then wq2_rptr advances to gray(1) -> wfull clears on the next edge; one write is accepted; wfull re-asserts.
- REQ-040: Write 40 words with the reader keeping pace -> wptr Gray sequence wraps at 31->0; each wptr step changes exactly one bit; no spurious wfull.
- REQ-041: Assert wrst_n=0 with wlevel=7 and both valid -> all outputs 0 on the next sample; after release, requester 0 is granted first.
